rs_multi_issue: RTL and testbench
=================================

Name: rs_multi_issue

Overview:
Parametrised reservation station that succeeds the single-dispatch RS, sitting between dispatch (ROB/free list) and the functional units. It accepts up to DISP_WIDTH instructions per cycle and wakes operands from CDB_WIDTH broadcast tags. Each cycle it issues at most one ready instruction per FU port, and it supports per-port stall and full flush.

Parameters:
RS_SIZE, 16, number of entries (power of 2 not required, 2..32)
DISP_WIDTH, 2, dispatch slots per cycle
CDB_WIDTH, 2, CDB tags broadcast per cycle
NUM_FU, 5, issue ports; port p serves fu_name encoding p (ALU=0, LD=1, ST=2, MULT=3, BR=4)
PREG_W, 6, physical register index width; tags are PREG_W+1 bits, MSB = ready flag

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
flush  in  1  squash all entries (branch mispredict)
disp_valid  in  DISP_WIDTH  per-slot dispatch request
disp_row  in  DISP_WIDTH x RS_ROW_T  instruction, T, T1, T2 (MSB of T1/T2 = ready)
disp_ready  out  1  free_cnt >= DISP_WIDTH
cdb_valid  in  CDB_WIDTH  tag broadcast valid
cdb_tag  in  CDB_WIDTH x PREG_W  broadcast tags
fu_ready  in  NUM_FU  port may accept issue this cycle (LSQ/MULT back-pressure)
issue_valid  out  NUM_FU  port p carries an instruction
issue_row  out  NUM_FU x RS_ROW_T  issued entry, busy=1
issue_cnt  out  $clog2(NUM_FU+1)  popcount(issue_valid & fu_ready)
free_cnt  out  $clog2(RS_SIZE+1)  free entries

Behaviour:
- Reset/flush state: all entries busy=0, tags = all-ones; free_cnt=RS_SIZE; issue_valid=0; disp_ready=1. Flush overrides dispatch and wakeup in the same cycle.
- Dispatch handshake: slots are accepted only when disp_ready=1, all-or-nothing. When disp_ready=0, disp_valid is ignored and nothing is written.
- Dispatch allocation: slot k takes the k-th lowest-index free entry. Invalid slots consume no entry. Entries freed by issue in the same cycle are not reusable until the next cycle.
- Dispatch/wakeup bypass: a dispatched T1/T2 whose index equals a valid cdb_tag in the same cycle is written with ready=1.
- Wakeup: for every busy entry and every valid CDB lane, a match on [PREG_W-1:0] sets the ready MSB at the clock edge. There is no same-cycle issue after wakeup; the entry becomes eligible next cycle.
- Eligibility: busy & T1 ready & T2 ready & fu_name==p. Eligibility comes from registered state only, so dispatch-to-issue latency is at least 1 cycle.
- Issue selection: port p outputs one eligible entry, chosen combinationally (see Optional Feature).
- Issue handshake: the entry is freed at the clock edge only if issue_valid[p] & fu_ready[p]. Otherwise it stays busy and is re-presented.
- Counting: free_cnt_next = free_cnt + issued - dispatched. It never underflows or overflows; assertion checks this.
- Simultaneous events: issue and wakeup on different entries are independent. An entry cannot be both freed and written in one cycle.
- Ignored tags: any tag with index all-ones (DUMMY_REG) is never matched.

Optional Feature:
RS_AGE_SELECT_EN
- Defined: an RS_SIZE x RS_SIZE age matrix. On allocation, row i records all currently busy entries plus lower-slot same-cycle dispatches as older. Each port issues the oldest eligible entry.
- Undefined: no age matrix; each port issues the highest-index eligible entry using the existing 16-bit priority tree.

Decomposition:
- Package rs_pkg: RS_ROW_T, PHYS_REG, FU_NAME enum (fixed encodings 0..4), DUMMY_REG.
- Sub-module rs_select: parametrised one-hot picker, taking a request vector plus optional age matrix and producing a one-hot grant. It is instantiated NUM_FU times and reused (without age) for free-entry allocation.

Test Plan:
1. Reset, then dispatch 2 ALU ops with both tags ready in cycle 1 -> free_cnt=14 in cycle 2; issue_valid[0]=1 in cycle 2; issue_cnt=1 in cycles 2 and 3; free_cnt=16 by cycle 4.
2. Dispatch MULT with T1=p5 not ready; cdb_tag=p5 valid 2 cycles later -> issue_valid[3]=1 exactly one cycle after the broadcast.
3. Dispatch an entry whose T2=p9 while cdb_tag=p9 is broadcast in the same cycle -> entry written ready and issues the next cycle.
4. Fill 16 entries with unready LDs -> disp_ready=0 at free_cnt<2; a further disp_valid is not written; free_cnt stays 0.
5. Hold fu_ready[1]=0 with a ready LD for 3 cycles -> issue_row[1] stable, entry stays busy; release -> freed next edge.
6. Flush together with disp_valid=2'b11 and a CDB hit -> all entries cleared, free_cnt=16, nothing written. With RS_AGE_SELECT_EN, two ready ALUs dispatched in different cycles into indices 7 then 3 -> index 7 issues first.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the multi-issue reservation station: row layout, tag format
// and FU encodings used by dispatch, the RS and the issue ports.
package rs_pkg;

    localparam int unsigned RS_PREG_W = 6;

    // Tag MSB is the ready flag, the low bits are the physical register index.
    typedef logic [RS_PREG_W:0] PHYS_REG;

    localparam logic [RS_PREG_W-1:0] DUMMY_REG = '1;

    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_LD   = 3'd1,
        FU_ST   = 3'd2,
        FU_MULT = 3'd3,
        FU_BR   = 3'd4
    } FU_NAME;

    typedef struct packed {
        logic        busy;
        FU_NAME      fu_name;
        logic [31:0] inst;
        PHYS_REG     T;
        PHYS_REG     T1;
        PHYS_REG     T2;
    } RS_ROW_T;

    localparam RS_ROW_T EMPTY_ROW = '{
        busy:    1'b0,
        fu_name: FU_ALU,
        inst:    '0,
        T:       '1,
        T1:      '1,
        T2:      '1
    };

endpackage

// File: rtl/rs_multi_issue_if.sv
// Dispatch / CDB / issue bundle between the rename stage, the RS and the FUs.
// master = dispatch + FU side, slave = reservation station.
interface rs_multi_issue_if
    import rs_pkg::*;
#(
    parameter int unsigned RS_SIZE    = 16,
    parameter int unsigned DISP_WIDTH = 2,
    parameter int unsigned CDB_WIDTH  = 2,
    parameter int unsigned NUM_FU     = 5,
    parameter int unsigned PREG_W     = RS_PREG_W
);
    localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);
    localparam int unsigned ISS_W = $clog2(NUM_FU + 1);

    logic                                flush;
    logic [DISP_WIDTH-1:0]               disp_valid;
    RS_ROW_T [DISP_WIDTH-1:0]            disp_row;
    logic                                disp_ready;
    logic [CDB_WIDTH-1:0]                cdb_valid;
    logic [CDB_WIDTH-1:0][PREG_W-1:0]    cdb_tag;
    logic [NUM_FU-1:0]                   fu_ready;
    logic [NUM_FU-1:0]                   issue_valid;
    RS_ROW_T [NUM_FU-1:0]                issue_row;
    logic [ISS_W-1:0]                    issue_cnt;
    logic [CNT_W-1:0]                    free_cnt;

    modport master (
        output flush, disp_valid, disp_row, cdb_valid, cdb_tag, fu_ready,
        input  disp_ready, issue_valid, issue_row, issue_cnt, free_cnt
    );

    modport slave (
        input  flush, disp_valid, disp_row, cdb_valid, cdb_tag, fu_ready,
        output disp_ready, issue_valid, issue_row, issue_cnt, free_cnt
    );

endinterface

// File: rtl/rs_select.sv
// One-hot picker: lowest- or highest-index request, or (AGE_EN) the request
// with no older requesting entry according to the age matrix.
module rs_select #(
    parameter int unsigned N         = 16,
    parameter bit          LOW_FIRST = 1'b1,
    parameter bit          AGE_EN    = 1'b0
) (
    input  logic [N-1:0]        req_i,
    input  logic [N-1:0][N-1:0] age_i,
    output logic [N-1:0]        gnt_o
);
    logic        found;
    int unsigned idx;

    // age_i[i][j] = 1 means entry j is older than entry i.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned n = 0; n < N; n++) begin
            idx = LOW_FIRST ? n : (N - 1 - n);
            if (!found && req_i[idx] && (!AGE_EN || ((age_i[idx] & req_i) == '0))) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_multi_issue.sv
// Multi-dispatch, multi-issue reservation station with CDB wakeup and flush.
// Define RS_AGE_SELECT_EN to issue oldest-first instead of highest-index-first.
module rs_multi_issue
    import rs_pkg::*;
#(
    parameter int unsigned RS_SIZE    = 16,
    parameter int unsigned DISP_WIDTH = 2,
    parameter int unsigned CDB_WIDTH  = 2,
    parameter int unsigned NUM_FU     = 5,
    parameter int unsigned PREG_W     = RS_PREG_W
) (
    input logic             clock,
    input logic             reset,
    rs_multi_issue_if.slave rs_if
);
    localparam int unsigned CNT_W  = $clog2(RS_SIZE + 1);
    localparam int unsigned ISS_W  = $clog2(NUM_FU + 1);
    localparam int unsigned DCNT_W = $clog2(DISP_WIDTH + 1);

    RS_ROW_T [RS_SIZE-1:0]              rows_q, rows_d;
    logic [CNT_W-1:0]                   free_cnt_q, free_cnt_d;
    logic [RS_SIZE-1:0]                 busy;
    logic [NUM_FU-1:0][RS_SIZE-1:0]     elig, issue_gnt;
    logic [DISP_WIDTH-1:0][RS_SIZE-1:0] alloc_gnt;
    logic [RS_SIZE-1:0][RS_SIZE-1:0]    age_mtx;
    logic [NUM_FU-1:0]                  fire;
    logic [RS_SIZE-1:0]                 freed;
    logic [ISS_W-1:0]                   iss_cnt;
    logic [DCNT_W-1:0]                  disp_cnt;
    logic [CNT_W-1:0]                   idle_cnt;
    logic                               accept;
    RS_ROW_T                            new_row;

    function automatic logic cdb_hit(
        input PHYS_REG                          tag,
        input logic [CDB_WIDTH-1:0]             vld,
        input logic [CDB_WIDTH-1:0][PREG_W-1:0] tags
    );
        cdb_hit = 1'b0;
        for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
            if (vld[l] && (tags[l] != DUMMY_REG) && (tags[l] == tag[PREG_W-1:0])) begin
                cdb_hit = 1'b1;
            end
        end
    endfunction

    assign accept           = (free_cnt_q >= CNT_W'(DISP_WIDTH));
    assign rs_if.disp_ready = accept;
    assign rs_if.free_cnt   = free_cnt_q;
    assign rs_if.issue_cnt  = iss_cnt;

    always_comb begin
        busy     = '0;
        idle_cnt = '0;
        elig     = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy[i] = rows_q[i].busy;
            if (!rows_q[i].busy) idle_cnt += CNT_W'(1);
            for (int unsigned p = 0; p < NUM_FU; p++) begin
                elig[p][i] = rows_q[i].busy && rows_q[i].T1[PREG_W] && rows_q[i].T2[PREG_W]
                             && (32'(rows_q[i].fu_name) == p);
            end
        end
    end

`ifdef RS_AGE_SELECT_EN
    localparam bit AGE_EN = 1'b1;

    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;
    logic [RS_SIZE-1:0]              older;

    // A new entry is younger than everything, so its column is cleared in all rows.
    always_comb begin
        age_d = age_q;
        older = '0;
        if (accept) begin
            for (int unsigned k = 0; k < DISP_WIDTH; k++) begin
                if (rs_if.disp_valid[k]) begin
                    for (int unsigned r = 0; r < RS_SIZE; r++) begin
                        age_d[r] = age_d[r] & ~alloc_gnt[k];
                        if (alloc_gnt[k][r]) age_d[r] = busy | older;
                    end
                    older = older | alloc_gnt[k];
                end
            end
        end
        if (rs_if.flush) age_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) age_q <= '0;
        else       age_q <= age_d;
    end

    assign age_mtx = age_q;
`else
    localparam bit AGE_EN = 1'b0;

    assign age_mtx = '0;
`endif

    for (genvar p = 0; p < NUM_FU; p++) begin : g_issue
        rs_select #(.N(RS_SIZE), .LOW_FIRST(1'b0), .AGE_EN(AGE_EN)) u_sel (
            .req_i (elig[p]),
            .age_i (age_mtx),
            .gnt_o (issue_gnt[p])
        );
    end

    // Each slot picks from what earlier valid slots left over; invalid slots pass it on.
    for (genvar k = 0; k < DISP_WIDTH; k++) begin : g_alloc
        logic [RS_SIZE-1:0] req;
        logic [RS_SIZE-1:0] gnt;
        if (k == 0) begin : g_first
            assign req = ~busy;
        end else begin : g_next
            assign req = rs_if.disp_valid[k-1] ? (g_alloc[k-1].req & ~g_alloc[k-1].gnt)
                                               : g_alloc[k-1].req;
        end
        rs_select #(.N(RS_SIZE), .LOW_FIRST(1'b1), .AGE_EN(1'b0)) u_sel (
            .req_i (req),
            .age_i ('0),
            .gnt_o (gnt)
        );
        assign alloc_gnt[k] = gnt;
    end

    always_comb begin
        rs_if.issue_row   = '0;
        rs_if.issue_valid = '0;
        fire              = '0;
        freed             = '0;
        iss_cnt           = '0;
        for (int unsigned p = 0; p < NUM_FU; p++) begin
            rs_if.issue_valid[p] = |issue_gnt[p];
            fire[p]              = (|issue_gnt[p]) && rs_if.fu_ready[p];
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (issue_gnt[p][i]) rs_if.issue_row[p] = rows_q[i];
            end
            if (fire[p]) begin
                freed   = freed | issue_gnt[p];
                iss_cnt = iss_cnt + ISS_W'(1);
            end
        end
    end

    always_comb begin
        rows_d   = rows_q;
        new_row  = EMPTY_ROW;
        disp_cnt = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (rows_q[i].busy) begin
                if (cdb_hit(rows_q[i].T1, rs_if.cdb_valid, rs_if.cdb_tag)) rows_d[i].T1[PREG_W] = 1'b1;
                if (cdb_hit(rows_q[i].T2, rs_if.cdb_valid, rs_if.cdb_tag)) rows_d[i].T2[PREG_W] = 1'b1;
            end
            if (freed[i]) rows_d[i] = EMPTY_ROW;
        end
        if (accept) begin
            for (int unsigned k = 0; k < DISP_WIDTH; k++) begin
                if (rs_if.disp_valid[k]) begin
                    disp_cnt     = disp_cnt + DCNT_W'(1);
                    new_row      = rs_if.disp_row[k];
                    new_row.busy = 1'b1;
                    if (cdb_hit(new_row.T1, rs_if.cdb_valid, rs_if.cdb_tag)) new_row.T1[PREG_W] = 1'b1;
                    if (cdb_hit(new_row.T2, rs_if.cdb_valid, rs_if.cdb_tag)) new_row.T2[PREG_W] = 1'b1;
                    for (int unsigned i = 0; i < RS_SIZE; i++) begin
                        if (alloc_gnt[k][i]) rows_d[i] = new_row;
                    end
                end
            end
        end
        if (rs_if.flush) rows_d = {RS_SIZE{EMPTY_ROW}};
    end

    assign free_cnt_d = rs_if.flush ? CNT_W'(RS_SIZE)
                                    : free_cnt_q + CNT_W'(iss_cnt) - CNT_W'(disp_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            rows_q     <= {RS_SIZE{EMPTY_ROW}};
            free_cnt_q <= CNT_W'(RS_SIZE);
        end else begin
            rows_q     <= rows_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (free_cnt_q == idle_cnt);
            assert (32'(free_cnt_q) + 32'(iss_cnt) >= 32'(disp_cnt));
            assert (32'(free_cnt_q) + 32'(iss_cnt) - 32'(disp_cnt) <= RS_SIZE);
        end
    end

endmodule

// File: tb/tb_rs_multi_issue.sv
// Directed bench for rs_multi_issue: issue order is tracked by a per-port scoreboard,
// counters and handshake timing by direct checks.
module tb_rs_multi_issue;
    import rs_pkg::*;

    localparam int unsigned NUM_FU = 5;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rs_multi_issue_if #(
        .RS_SIZE(16), .DISP_WIDTH(2), .CDB_WIDTH(2), .NUM_FU(NUM_FU), .PREG_W(RS_PREG_W)
    ) bus ();

    rs_multi_issue #(
        .RS_SIZE(16), .DISP_WIDTH(2), .CDB_WIDTH(2), .NUM_FU(NUM_FU), .PREG_W(RS_PREG_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rs_if (bus)
    );

    typedef struct {
        int          port;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic PHYS_REG rdy(input logic [5:0] idx);
        return {1'b1, idx};
    endfunction

    function automatic PHYS_REG nrdy(input logic [5:0] idx);
        return {1'b0, idx};
    endfunction

    function automatic RS_ROW_T mk(input FU_NAME fu, input logic [31:0] inst,
                                   input PHYS_REG t1, input PHYS_REG t2);
        RS_ROW_T r;
        r.busy    = 1'b1;
        r.fu_name = fu;
        r.inst    = inst;
        r.T       = {1'b0, 6'd20};
        r.T1      = t1;
        r.T2      = t2;
        return r;
    endfunction

    task automatic sb_push(input int port, input logic [31:0] inst);
        exp_t e;
        e.port = port;
        e.inst = inst;
        sb.push_back(e);
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.disp_valid  = '0;
        bus.disp_row    = '0;
        bus.cdb_valid   = '0;
        bus.cdb_tag     = '0;
    endtask

    task automatic disp(input logic [1:0] v, input RS_ROW_T r0, input RS_ROW_T r1);
        bus.disp_valid  = v;
        bus.disp_row[0] = r0;
        bus.disp_row[1] = r1;
    endtask

    // Every issue that fires at the coming edge must be the next one expected on its port.
    task automatic monitor();
        int hit;
        for (int p = 0; p < NUM_FU; p++) begin
            if (bus.issue_valid[p] && bus.fu_ready[p]) begin
                hit = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].port == p) begin
                        hit = j;
                        break;
                    end
                end
                check($sformatf("sb_inst_port%0d", p), 64'(bus.issue_row[p].inst),
                      (hit < 0) ? 64'hDEAD_DEAD : 64'(sb[hit].inst));
                check($sformatf("sb_busy_port%0d", p), 64'(bus.issue_row[p].busy), 64'h1);
                if (hit >= 0) sb.delete(hit);
            end
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.fu_ready = '1;
        reset        = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_free_cnt",   64'(bus.free_cnt),    64'd16);
        check("rst_disp_ready", 64'(bus.disp_ready),  64'h1);
        check("rst_issue_vld",  64'(bus.issue_valid), 64'h0);
        check("rst_issue_cnt",  64'(bus.issue_cnt),   64'h0);

        // Two ready ALU ops in one dispatch cycle.
`ifdef RS_AGE_SELECT_EN
        sb_push(0, 32'h101);
        sb_push(0, 32'h102);
`else
        sb_push(0, 32'h102);
        sb_push(0, 32'h101);
`endif
        disp(2'b11, mk(FU_ALU, 32'h101, rdy(1), rdy(2)), mk(FU_ALU, 32'h102, rdy(3), rdy(4)));
        tick();
        idle();
        check("t1_free_c2",  64'(bus.free_cnt),    64'd14);
        check("t1_ivld_c2",  64'(bus.issue_valid), 64'h01);
        check("t1_icnt_c2",  64'(bus.issue_cnt),   64'd1);
        tick();
        check("t1_icnt_c3",  64'(bus.issue_cnt),   64'd1);
        check("t1_free_c3",  64'(bus.free_cnt),    64'd15);
        tick();
        check("t1_free_c4",  64'(bus.free_cnt),    64'd16);
        check("t1_ivld_c4",  64'(bus.issue_valid), 64'h0);

        // MULT waiting on p5, woken two cycles after dispatch.
        sb_push(3, 32'h200);
        disp(2'b01, mk(FU_MULT, 32'h200, nrdy(5), rdy(7)), '0);
        tick();
        idle();
        check("t2_ivld_wait0", 64'(bus.issue_valid[3]), 64'h0);
        check("t2_free",       64'(bus.free_cnt),       64'd15);
        tick();
        check("t2_ivld_wait1", 64'(bus.issue_valid[3]), 64'h0);
        bus.cdb_valid  = 2'b01;
        bus.cdb_tag[0] = 6'd5;
        tick();
        idle();
        check("t2_ivld_woken", 64'(bus.issue_valid[3]),   64'h1);
        check("t2_row_t1",     64'(bus.issue_row[3].T1),  64'(rdy(5)));
        tick();
        check("t2_ivld_done",  64'(bus.issue_valid[3]), 64'h0);
        check("t2_free_done",  64'(bus.free_cnt),       64'd16);

        // Same-cycle CDB bypass on dispatch, plus a second port issuing alongside.
        sb_push(2, 32'h300);
        sb_push(0, 32'h301);
        disp(2'b11, mk(FU_ST, 32'h300, rdy(3), nrdy(9)), mk(FU_ALU, 32'h301, rdy(11), rdy(12)));
        bus.cdb_valid  = 2'b10;
        bus.cdb_tag[1] = 6'd9;
        tick();
        idle();
        check("t3_ivld",    64'(bus.issue_valid),     64'h05);
        check("t3_icnt",    64'(bus.issue_cnt),       64'd2);
        check("t3_row_t2",  64'(bus.issue_row[2].T2), 64'(rdy(9)));
        tick();
        check("t3_free",    64'(bus.free_cnt),        64'd16);

        // LD port back-pressured for three cycles.
        bus.fu_ready = 5'b11101;
        sb_push(1, 32'h500);
        disp(2'b01, mk(FU_LD, 32'h500, rdy(13), rdy(14)), '0);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t5_ivld_c%0d", c), 64'(bus.issue_valid[1]), 64'h1);
            check($sformatf("t5_row_c%0d", c),  64'(bus.issue_row[1]),
                  64'(mk(FU_LD, 32'h500, rdy(13), rdy(14))));
            check($sformatf("t5_free_c%0d", c), 64'(bus.free_cnt), 64'd15);
            check($sformatf("t5_icnt_c%0d", c), 64'(bus.issue_cnt), 64'd0);
            if (c < 2) tick();
        end
        bus.fu_ready = '1;
        tick();
        check("t5_ivld_rel", 64'(bus.issue_valid[1]), 64'h0);
        check("t5_free_rel", 64'(bus.free_cnt),       64'd16);

        // Two ALUs dispatched a cycle apart into entries 0 then 1.
        bus.fu_ready = 5'b11110;
        disp(2'b01, mk(FU_ALU, 32'h601, rdy(1), rdy(1)), '0);
        tick();
        disp(2'b01, mk(FU_ALU, 32'h602, rdy(2), rdy(2)), '0);
        tick();
        idle();
        check("t7_ivld", 64'(bus.issue_valid[0]), 64'h1);
`ifdef RS_AGE_SELECT_EN
        check("t7_pick", 64'(bus.issue_row[0].inst), 64'h601);
        sb_push(0, 32'h601);
        sb_push(0, 32'h602);
`else
        check("t7_pick", 64'(bus.issue_row[0].inst), 64'h602);
        sb_push(0, 32'h602);
        sb_push(0, 32'h601);
`endif
        bus.fu_ready = '1;
        tick();
        tick();
        check("t7_free", 64'(bus.free_cnt), 64'd16);

        // Fill with LDs waiting on the dummy register while it is broadcast.
        bus.cdb_valid  = 2'b01;
        bus.cdb_tag[0] = DUMMY_REG;
        disp(2'b10, mk(FU_ALU, 32'hBAD0, rdy(1), rdy(1)), mk(FU_LD, 32'h400, nrdy(63), rdy(1)));
        tick();
        check("t4_free_single", 64'(bus.free_cnt), 64'd15);
        for (int n = 0; n < 7; n++) begin
            check($sformatf("t4_dready_%0d", n), 64'(bus.disp_ready), 64'h1);
            disp(2'b11, mk(FU_LD, 32'h410 + 32'(n), nrdy(63), rdy(1)),
                        mk(FU_LD, 32'h420 + 32'(n), nrdy(63), rdy(1)));
            tick();
            check($sformatf("t4_free_%0d", n), 64'(bus.free_cnt), 64'(15 - 2 * (n + 1)));
        end
        check("t4_dready_full", 64'(bus.disp_ready), 64'h0);
        disp(2'b11, mk(FU_ALU, 32'hBAD1, rdy(1), rdy(1)), mk(FU_ALU, 32'hBAD2, rdy(1), rdy(1)));
        tick();
        disp(2'b00, '0, '0);
        check("t4_free_blocked", 64'(bus.free_cnt),    64'd1);
        check("t4_ivld_blocked", 64'(bus.issue_valid), 64'h0);
        tick();
        check("t4_ivld_dummy",   64'(bus.issue_valid), 64'h0);
        check("t4_free_dummy",   64'(bus.free_cnt),    64'd1);

        // Flush from a full station, then flush racing a dispatch and a wakeup.
        bus.flush      = 1'b1;
        bus.cdb_valid  = 2'b11;
        bus.cdb_tag[0] = 6'd1;
        bus.cdb_tag[1] = 6'd2;
        disp(2'b11, mk(FU_ALU, 32'hBAD3, rdy(1), rdy(1)), mk(FU_ALU, 32'hBAD4, rdy(1), rdy(1)));
        tick();
        idle();
        check("t6_free_flush1",  64'(bus.free_cnt),    64'd16);
        check("t6_ivld_flush1",  64'(bus.issue_valid), 64'h0);
        check("t6_dready_flush", 64'(bus.disp_ready),  64'h1);
        disp(2'b11, mk(FU_MULT, 32'h700, nrdy(30), rdy(1)), mk(FU_MULT, 32'h701, nrdy(30), rdy(1)));
        tick();
        check("t6_free_refill",  64'(bus.free_cnt),    64'd14);
        bus.flush      = 1'b1;
        bus.cdb_valid  = 2'b01;
        bus.cdb_tag[0] = 6'd30;
        disp(2'b11, mk(FU_ALU, 32'hBAD5, rdy(1), rdy(1)), mk(FU_ALU, 32'hBAD6, rdy(1), rdy(1)));
        tick();
        idle();
        check("t6_free_flush2",  64'(bus.free_cnt),    64'd16);
        check("t6_ivld_flush2",  64'(bus.issue_valid), 64'h0);
        tick();
        check("t6_free_after",   64'(bus.free_cnt),    64'd16);
        check("t6_ivld_after",   64'(bus.issue_valid), 64'h0);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
